// File: rtl/eg_pkg.sv
// Shared types and widths for the Exp-Golomb bit-serial encoder.
package eg_pkg;

   localparam int VAL_W_DEF = 16;
   localparam int M_W       = 5;
   localparam int LEN_W     = 6;
   localparam int X_W_DEF   = VAL_W_DEF + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      SUFFIX = 2'd2
   } state_t;

endpackage

// File: rtl/eg_msb_find.sv
// Combinational index of the highest set bit; returns 0 for an all-zero input.
module eg_msb_find
   import eg_pkg::*;
#(
   parameter int X_W = X_W_DEF
) (
   input  logic [X_W-1:0] x,
   output logic [M_W-1:0] idx
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < X_W; i++) begin
         if (x[i]) idx = M_W'(i);
      end
   end

endmodule

// File: rtl/eg_encoder.sv
// Exp-Golomb ue(v)/se(v) encoder: one value in, a serial codeword of 2M+1 bits out, MSB first.
module eg_encoder
   import eg_pkg::*;
#(
   parameter int VAL_W = VAL_W_DEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VAL_W-1:0] in_value,
   input  logic             in_signed,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             bit_data,
   output logic             bit_last,
   output logic [LEN_W-1:0] cw_len
);

   localparam int XW = VAL_W + 1;
   localparam logic signed [XW:0] ONE_S = 1;
   localparam logic [XW-1:0]      ONE_X = 1;

   state_t            state, state_next;
   logic signed [XW:0] v_ext, v_dbl, se_code;
   logic [XW-1:0]     code_num, x_new, x_reg, x_sh;
   logic [M_W-1:0]    m_new, cnt, idx;

   // One extra bit of headroom so 2v cannot overflow before the se mapping.
   always_comb begin
      v_ext    = {{2{in_value[VAL_W-1]}}, in_value};
      v_dbl    = v_ext <<< 1;
      se_code  = (!in_value[VAL_W-1] && (in_value != '0)) ? (v_dbl - ONE_S) : (-v_dbl);
      code_num = in_signed ? se_code[XW-1:0] : {1'b0, in_value};
      x_new    = code_num + ONE_X;
   end

   eg_msb_find #(.X_W(XW)) u_msb_find (
      .x   (x_new),
      .idx (m_new)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) state <= IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = (m_new != '0) ? PREFIX : SUFFIX;
         PREFIX:  if (bit_ready && (cnt == 5'd1)) state_next = SUFFIX;
         SUFFIX:  if (bit_ready && (idx == '0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Everything downstream-visible decodes from the held state/registers, so a stall freezes it.
   always_comb begin
      x_sh      = x_reg >> idx;
      in_ready  = (state == IDLE);
      bit_valid = (state == PREFIX) || (state == SUFFIX);
      bit_data  = (state == SUFFIX) && x_sh[0];
      bit_last  = (state == SUFFIX) && (idx == '0);
   end

   always_ff @(posedge wb_clk_i) begin
      if ((state == IDLE) && in_valid) x_reg <= x_new;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         cnt    <= '0;
         idx    <= '0;
         cw_len <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               cnt    <= m_new;
               idx    <= m_new;
               cw_len <= {m_new, 1'b1};
            end
            PREFIX: if (bit_ready) cnt <= cnt - 5'd1;
            SUFFIX: if (bit_ready) begin
               if (idx == '0) cw_len <= '0;
               else           idx    <= idx - 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eg_encoder.sv
// Directed bench for eg_encoder: codeword contents, timing, stalls, reset and back-to-back use.
module tb_eg_encoder;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic        in_signed;
   logic        bit_valid;
   logic        bit_ready;
   logic        bit_data;
   logic        bit_last;
   logic [5:0]  cw_len;

   int n_cmp  = 0;
   int n_fail = 0;

   eg_encoder #(.VAL_W(16)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n  (wb_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_signed (in_signed),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_data  (bit_data),
      .bit_last  (bit_last),
      .cw_len    (cw_len)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Offer one value for a single accepting edge; returns at the first negedge after acceptance.
   task automatic offer(input logic [15:0] v, input logic s);
      in_valid  = 1'b1;
      in_value  = v;
      in_signed = s;
      @(negedge wb_clk_i);
      in_valid  = 1'b0;
   endtask

   // Collect handshaken bits until bit_last; returns at the negedge following the last handshake.
   task automatic capture(output logic [63:0] obs, output int n, output int delay,
                          output logic [5:0] cwl, output bit cw_stable);
      obs = '0; n = 0; delay = 0; cwl = '0; cw_stable = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (bit_valid && bit_ready) begin
            if (n == 0) cwl = cw_len;
            else if (cw_len !== cwl) cw_stable = 1'b0;
            obs = {obs[62:0], bit_data};
            n++;
            if (bit_last) begin
               @(negedge wb_clk_i);
               return;
            end
         end else if (n == 0) begin
            delay++;
         end
         @(negedge wb_clk_i);
      end
   endtask

   task automatic test_reset();
      wb_rst_n = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      n_cmp++;
      if ({in_ready, bit_valid, bit_data, bit_last, cw_len} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b vld=%b dat=%b last=%b len=%0d, want 1 0 0 0 0",
                  in_ready, bit_valid, bit_data, bit_last, cw_len);
      end
      wb_rst_n = 1'b1;
      @(negedge wb_clk_i);
   endtask

   task automatic test_ue_zero();
      logic [63:0] obs; int n, delay; logic [5:0] cwl; bit st;
      offer(16'd0, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL ue0_busy: in_ready=%b want 0", in_ready);
      end
      capture(obs, n, delay, cwl, st);
      n_cmp++;
      if (n !== 1 || obs !== 64'd1 || delay !== 0 || cwl !== 6'd1) begin
         n_fail++;
         $display("FAIL ue0_code: got n=%0d bits=%0h delay=%0d len=%0d, want 1 1 0 1", n, obs, delay, cwl);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || bit_valid !== 1'b0 || cw_len !== 6'd0) begin
         n_fail++;
         $display("FAIL ue0_idle: got rdy=%b vld=%b len=%0d, want 1 0 0", in_ready, bit_valid, cw_len);
      end
   endtask

   task automatic test_codes();
      logic [15:0] tv  [5] = '{16'd3, 16'hFFFE, 16'd1, 16'd65535, 16'h8000};
      logic        ts  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [63:0] tex [5] = '{64'h4, 64'h5, 64'h2, 64'h10000, 64'h10001};
      int          tn  [5] = '{5, 5, 3, 33, 33};
      logic [63:0] obs; int n, delay; logic [5:0] cwl; bit st;
      for (int k = 0; k < 5; k++) begin
         offer(tv[k], ts[k]);
         capture(obs, n, delay, cwl, st);
         n_cmp++;
         if (n !== tn[k] || obs !== tex[k]) begin
            n_fail++;
            $display("FAIL code_bits[%0d]: got n=%0d bits=%0h, want n=%0d bits=%0h", k, n, obs, tn[k], tex[k]);
         end
         n_cmp++;
         if (cwl !== 6'(tn[k]) || !st || delay !== 0) begin
            n_fail++;
            $display("FAIL code_len[%0d]: got len=%0d stable=%0b delay=%0d, want %0d 1 0", k, cwl, st, delay, tn[k]);
         end
         n_cmp++;
         if (in_ready !== 1'b1 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL code_idle[%0d]: got rdy=%b vld=%b, want 1 0", k, in_ready, bit_valid);
         end
      end
   endtask

   task automatic test_stall();
      logic [63:0] obs = '0;
      int n = 0;
      bit done = 1'b0;
      logic prev_rdy = 1'b1;
      logic [7:0] prev = '0;
      offer(16'd7, 1'b0);
      for (int c = 0; c < 100 && !done; c++) begin
         bit_ready = !((c % 4) == 1 || (c % 4) == 2);
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_busy: cycle %0d in_ready=%b want 0", c, in_ready);
         end
         if (!prev_rdy) begin
            n_cmp++;
            if ({bit_data, bit_last, cw_len} !== prev) begin
               n_fail++;
               $display("FAIL stall_hold: cycle %0d got %0h want %0h", c, {bit_data, bit_last, cw_len}, prev);
            end
         end
         prev     = {bit_data, bit_last, cw_len};
         prev_rdy = bit_ready;
         if (bit_valid && bit_ready) begin
            obs = {obs[62:0], bit_data};
            n++;
            done = bit_last;
         end
         @(negedge wb_clk_i);
      end
      bit_ready = 1'b1;
      n_cmp++;
      if (n !== 7 || obs !== 64'h8) begin
         n_fail++; $display("FAIL stall_bits: got n=%0d bits=%0h, want 7 8", n, obs);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_idle: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] obs; int n, delay; logic [5:0] cwl; bit st;
      offer(16'd100, 1'b0);
      repeat (2) @(negedge wb_clk_i);
      wb_rst_n = 1'b0;
      @(negedge wb_clk_i);
      n_cmp++;
      if (bit_valid !== 1'b0 || in_ready !== 1'b1 || cw_len !== 6'd0) begin
         n_fail++;
         $display("FAIL midrst_state: got vld=%b rdy=%b len=%0d, want 0 1 0", bit_valid, in_ready, cw_len);
      end
      wb_rst_n = 1'b1;
      offer(16'd1, 1'b0);
      capture(obs, n, delay, cwl, st);
      n_cmp++;
      if (n !== 3 || obs !== 64'h2 || delay !== 0 || cwl !== 6'd3) begin
         n_fail++;
         $display("FAIL midrst_code: got n=%0d bits=%0h delay=%0d len=%0d, want 3 2 0 3", n, obs, delay, cwl);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] obs; int n, delay; logic [5:0] cwl; bit st;
      in_valid  = 1'b1;
      in_value  = 16'd1;
      in_signed = 1'b0;
      @(negedge wb_clk_i);
      in_value = 16'd2;
      capture(obs, n, delay, cwl, st);
      n_cmp++;
      if (n !== 3 || obs !== 64'h2) begin
         n_fail++; $display("FAIL b2b_first: got n=%0d bits=%0h, want 3 2", n, obs);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || bit_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap: got rdy=%b vld=%b, want 1 0", in_ready, bit_valid);
      end
      @(negedge wb_clk_i);
      in_valid = 1'b0;
      capture(obs, n, delay, cwl, st);
      n_cmp++;
      if (n !== 3 || obs !== 64'h3 || delay !== 0) begin
         n_fail++; $display("FAIL b2b_second: got n=%0d bits=%0h delay=%0d, want 3 3 0", n, obs, delay);
      end
   endtask

   initial begin
      wb_rst_n  = 1'b0;
      in_valid  = 1'b0;
      in_value  = '0;
      in_signed = 1'b0;
      bit_ready = 1'b1;
      @(negedge wb_clk_i);
      test_reset();
      test_ue_zero();
      test_codes();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
